// File: rtl/delay_block_writer_pkg.sv
// Shared block geometry and FSM state encoding for the coefficient delay line.
// The delay RAM and the reader draw their geometry from the same constants.
package delay_block_writer_pkg;

  localparam int unsigned DEF_LENGTH     = 6;
  localparam int unsigned DEF_WIDTH      = 16;
  localparam int unsigned DEF_BLOCK_SIZE = 512;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    WAIT  = 2'd1,
    SHIFT = 2'd2
  } state_t;

endpackage

// File: rtl/delay_block_writer.sv
// Write-side controller for the coefficient delay line: fills one block per slot,
// then rotates the line once the reader is done (or nothing is readable yet).
module delay_block_writer
  import delay_block_writer_pkg::*;
#(
  parameter int unsigned LENGTH     = DEF_LENGTH,
  parameter int unsigned WIDTH      = DEF_WIDTH,
  parameter int unsigned BLOCK_SIZE = DEF_BLOCK_SIZE
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [WIDTH-1:0]              s_data,
  input  logic                          rd_done,
  output logic                          rd_valid,
  output logic                          we_in,
  output logic [$clog2(BLOCK_SIZE)-1:0] addr_in,
  output logic [WIDTH-1:0]              di_in,
  output logic                          shift
);

  localparam int unsigned AW = $clog2(BLOCK_SIZE);
  localparam int unsigned FW = $clog2(LENGTH + 2);
  localparam logic [AW-1:0] LAST_ADDR = AW'(BLOCK_SIZE - 1);
  localparam logic [FW-1:0] FILL_MAX  = FW'(LENGTH + 1);

  state_t            state;
  state_t            state_next;
  logic [AW-1:0]     wr_cnt;
  logic [AW-1:0]     wr_cnt_next;
  logic [FW-1:0]     fill_cnt;
  logic [FW-1:0]     fill_cnt_next;
  logic              rd_done_seen;
  logic              rd_done_seen_next;
  logic              we_next;
  logic [AW-1:0]     addr_next;
  logic [WIDTH-1:0]  di_next;
  logic              s_ready_next;
  logic              shift_next;
  logic              rd_valid_next;
  logic              hs;
  logic              go;

  // s_ready is a registered image of (state == FILL), so it qualifies the handshake directly
  assign hs = s_valid & s_ready;
  assign go = !rd_valid || rd_done_seen || rd_done;

  // State, counters and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= FILL;
      wr_cnt       <= '0;
      fill_cnt     <= '0;
      rd_done_seen <= 1'b0;
      s_ready      <= 1'b1;
      we_in        <= 1'b0;
      addr_in      <= '0;
      di_in        <= '0;
      shift        <= 1'b0;
      rd_valid     <= 1'b0;
    end else begin
      state        <= state_next;
      wr_cnt       <= wr_cnt_next;
      fill_cnt     <= fill_cnt_next;
      rd_done_seen <= rd_done_seen_next;
      s_ready      <= s_ready_next;
      we_in        <= we_next;
      addr_in      <= addr_next;
      di_in        <= di_next;
      shift        <= shift_next;
      rd_valid     <= rd_valid_next;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_next        = state;
    wr_cnt_next       = wr_cnt;
    fill_cnt_next     = fill_cnt;
    rd_done_seen_next = rd_done_seen | rd_done;
    we_next           = 1'b0;
    addr_next         = addr_in;
    di_next           = di_in;

    case (state)
      FILL: begin
        if (hs) begin
          we_next     = 1'b1;
          addr_next   = wr_cnt;
          di_next     = s_data;
          wr_cnt_next = wr_cnt + AW'(1);
          if (wr_cnt == LAST_ADDR) begin
            state_next = WAIT;
          end
        end
      end
      WAIT: begin
        if (go) begin
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        // a done pulse in the shift cycle is a reader protocol error and is dropped
        rd_done_seen_next = 1'b0;
        if (fill_cnt != FILL_MAX) begin
          fill_cnt_next = fill_cnt + FW'(1);
        end
        state_next = FILL;
      end
      default: begin
        state_next = FILL;
      end
    endcase

    s_ready_next  = (state_next == FILL);
    shift_next    = (state_next == SHIFT);
    rd_valid_next = rd_valid | (fill_cnt_next == FILL_MAX);
  end

endmodule

// File: tb/tb_delay_block_writer.sv
// Directed bench for delay_block_writer: reset, priming, backpressure, early done,
// bursty input and mid-block reset, with hand-derived expectations.
module tb_delay_block_writer;

  localparam int unsigned AW = 9;

  logic          clk;
  logic          rst_n;
  logic          s_valid;
  logic          s_ready;
  logic [15:0]   s_data;
  logic          rd_done;
  logic          rd_valid;
  logic          we_in;
  logic [AW-1:0] addr_in;
  logic [15:0]   di_in;
  logic          shift;

  int checks;
  int errors;

  delay_block_writer #(
    .LENGTH     (6),
    .WIDTH      (16),
    .BLOCK_SIZE (512)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .rd_done  (rd_done),
    .rd_valid (rd_valid),
    .we_in    (we_in),
    .addr_in  (addr_in),
    .di_in    (di_in),
    .shift    (shift)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Streams n coefficients base+i; pulses rd_done once when wr_cnt reaches done_at.
  // Returns one cycle after the last accepted handshake (the cycle of the last write).
  task automatic push_block(input logic [15:0] base, input int n, input bit bursty,
                            input int done_at);
    int acc;
    int bad;
    int cyc;
    int first_bad;
    bit v;
    bit hs;
    bit done_sent;
    logic [15:0] exp_data;
    acc = 0; bad = 0; cyc = 0; first_bad = -1; done_sent = 0;
    while (acc < n && cyc < 4 * n + 20) begin
      v = bursty ? 1'($urandom_range(0, 1)) : 1'b1;
      s_valid = v;
      s_data  = v ? base + 16'(acc) : 16'hDEAD;
      if (!done_sent && acc == done_at) begin
        rd_done = 1'b1;
        done_sent = 1;
      end
      hs = v && s_ready;
      exp_data = base + 16'(acc);
      step();
      rd_done = 1'b0;
      cyc++;
      if (hs) begin
        if (we_in !== 1'b1 || addr_in !== AW'(acc) || di_in !== exp_data) begin
          bad++;
          if (first_bad < 0) first_bad = acc;
        end
        acc++;
      end else if (we_in !== 1'b0) begin
        bad++;
        if (first_bad < 0) first_bad = acc;
      end
    end
    s_valid = 1'b0;
    checks++;
    if (bad !== 0 || acc !== n) begin
      errors++;
      $display("FAIL push_block base=%h: bad_writes=%0d (first at %0d) accepted=%0d, required 0 bad and %0d accepted",
               base, bad, first_bad, acc, n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; s_valid = 1'b1; s_data = 16'h5555; rd_done = 1'b0;
    repeat (3) step();
    checks++;
    if ({we_in, shift, s_ready, rd_valid} !== 4'b0010) begin
      errors++;
      $display("FAIL reset_flags: we/shift/ready/rd_valid=%b required 0010",
               {we_in, shift, s_ready, rd_valid});
    end
    checks++;
    if (addr_in !== 9'd0 || di_in !== 16'd0) begin
      errors++;
      $display("FAIL reset_bus: addr=%0d di=%h required 0 and 0000", addr_in, di_in);
    end
    rst_n = 1'b1; s_data = 16'hABCD;
    step();
    s_valid = 1'b0;
    checks++;
    if (we_in !== 1'b1 || addr_in !== 9'd0 || di_in !== 16'hABCD) begin
      errors++;
      $display("FAIL first_write: we=%b addr=%0d di=%h required 1, 0, abcd", we_in, addr_in, di_in);
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_prime();
    for (int b = 0; b < 7; b++) begin
      push_block(16'(b * 512), 512, 1'b0, -1);
      checks++;
      if (s_ready !== 1'b0 || shift !== 1'b0) begin
        errors++;
        $display("FAIL prime_wait blk=%0d: ready=%b shift=%b required 0 0", b, s_ready, shift);
      end
      step();
      checks++;
      if (shift !== 1'b1 || we_in !== 1'b0 || s_ready !== 1'b0 || rd_valid !== 1'b0) begin
        errors++;
        $display("FAIL prime_shift blk=%0d: shift=%b we=%b ready=%b rd_valid=%b required 1 0 0 0",
                 b, shift, we_in, s_ready, rd_valid);
      end
      step();
      checks++;
      if (shift !== 1'b0 || s_ready !== 1'b1 || rd_valid !== (b == 6)) begin
        errors++;
        $display("FAIL prime_after blk=%0d: shift=%b ready=%b rd_valid=%b required 0 1 %0d",
                 b, shift, s_ready, rd_valid, (b == 6));
      end
    end
  endtask

  task automatic test_backpressure();
    int bad;
    bad = 0;
    push_block(16'h1000, 512, 1'b0, -1);
    for (int i = 0; i < 20; i++) begin
      step();
      if (shift !== 1'b0 || s_ready !== 1'b0 || we_in !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL stall: %0d stall cycles with shift/ready/we set, required 0", bad);
    end
    rd_done = 1'b1;
    step();
    rd_done = 1'b0;
    checks++;
    if (shift !== 1'b1 || s_ready !== 1'b0) begin
      errors++;
      $display("FAIL release_shift: shift=%b ready=%b required 1 0", shift, s_ready);
    end
    step();
    checks++;
    if (shift !== 1'b0 || s_ready !== 1'b1 || rd_valid !== 1'b1) begin
      errors++;
      $display("FAIL release_ready: shift=%b ready=%b rd_valid=%b required 0 1 1", shift, s_ready, rd_valid);
    end
  endtask

  task automatic test_early_done(input logic [15:0] base, input bit bursty, input int done_at);
    push_block(base, 512, bursty, done_at);
    step();
    checks++;
    if (shift !== 1'b1 || we_in !== 1'b0) begin
      errors++;
      $display("FAIL early_shift base=%h: shift=%b we=%b required 1 0", base, shift, we_in);
    end
    step();
    checks++;
    if (shift !== 1'b0 || s_ready !== 1'b1) begin
      errors++;
      $display("FAIL early_ready base=%h: shift=%b ready=%b required 0 1", base, shift, s_ready);
    end
  endtask

  task automatic test_mid_reset();
    push_block(16'h5000, 300, 1'b0, -1);
    rst_n = 1'b0; s_valid = 1'b1; s_data = 16'h1234;
    step();
    rst_n = 1'b1; s_valid = 1'b0;
    checks++;
    if ({we_in, shift, s_ready, rd_valid} !== 4'b0010 || addr_in !== 9'd0 || di_in !== 16'd0) begin
      errors++;
      $display("FAIL mid_reset: we/shift/ready/rd_valid=%b addr=%0d di=%h required 0010, 0, 0000",
               {we_in, shift, s_ready, rd_valid}, addr_in, di_in);
    end
    // wr_cnt restarts at 0 and, with nothing readable, the shift goes out unprompted
    push_block(16'h6000, 512, 1'b0, -1);
    step();
    checks++;
    if (shift !== 1'b1 || rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_shift: shift=%b rd_valid=%b required 1 0", shift, rd_valid);
    end
    step();
    checks++;
    if (s_ready !== 1'b1 || rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_ready: ready=%b rd_valid=%b required 1 0", s_ready, rd_valid);
    end
    // reset in WAIT cancels the pending shift
    push_block(16'h7000, 512, 1'b0, -1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    checks++;
    if (shift !== 1'b0 || s_ready !== 1'b1) begin
      errors++;
      $display("FAIL cancel_shift: shift=%b ready=%b required 0 1", shift, s_ready);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0; s_valid = 1'b0; s_data = '0; rd_done = 1'b0;
    test_reset();
    test_prime();
    test_backpressure();
    test_early_done(16'h2000, 1'b0, 100);
    test_early_done(16'h3000, 1'b1, 50);
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
